// File: rtl/types_pkg.sv
// Shared types for the model instance scheduler: FSM states, memory word
// layouts and the instance / triangle stream payloads.
package types_pkg;

    localparam int MODEL_ID_W = 8;
    localparam int TRI_ADDR_W = 12;
    localparam int COUNT_W    = 12;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        TRI_RD,
        TRI_WAIT,
        EMIT
    } sched_state_t;

    typedef struct packed {
        logic [TRI_ADDR_W-1:0] base_addr;
        logic [COUNT_W-1:0]    tri_count;
    } model_header_t;

    typedef struct packed {
        logic [15:0] tx;
        logic [15:0] ty;
        logic [15:0] tz;
        logic [15:0] scale;
    } transform_t;

    typedef struct packed {
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v2;
    } triangle_t;

    typedef struct packed {
        logic [MODEL_ID_W-1:0] model_id;
        transform_t            transform;
    } modelinstance_t;

    typedef struct packed {
        triangle_t  tri_v;
        transform_t transform;
    } triangle_tf_t;

endpackage

// File: rtl/model_instance_scheduler.sv
// Walks one model instance at a time through header and triangle memories and
// streams transformed-triangle records. Define SCHED_STATS_EN for statistics counters.
module model_instance_scheduler
    import types_pkg::*;
(
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  modelinstance_t                inst,
    output logic [MODEL_ID_W-1:0]         hdr_addr,
    input  logic [TRI_ADDR_W+COUNT_W-1:0] hdr_data,
    output logic [TRI_ADDR_W-1:0]         tri_addr,
    input  triangle_t                     tri_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output triangle_tf_t                  out_data,
    output logic                          out_last,
    output logic                          busy
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_instances,
    output logic [31:0]                   stat_triangles,
    output logic [15:0]                   stat_dropped
`endif
);

    sched_state_t          state_q, state_d;
    transform_t            xf_q;
    logic [COUNT_W-1:0]    remaining_q;
    logic [MODEL_ID_W-1:0] hdr_addr_q;
    logic [TRI_ADDR_W-1:0] tri_addr_q;
    triangle_tf_t          out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    model_header_t         hdr;
    logic                  inst_fire;
    logic                  out_fire;
    logic                  hdr_empty;

    assign hdr       = model_header_t'(hdr_data);
    assign hdr_empty = (hdr.tri_count == '0);
    assign inst_fire = inst_valid && inst_ready;
    assign out_fire  = (state_q == EMIT) && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (inst_fire) state_d = HDR_RD;
            HDR_RD:   state_d = HDR_WAIT;
            HDR_WAIT: state_d = hdr_empty ? IDLE : TRI_RD;
            TRI_RD:   state_d = TRI_WAIT;
            TRI_WAIT: state_d = EMIT;
            EMIT:     if (out_ready) state_d = out_last_q ? IDLE : TRI_RD;
            default:  state_d = IDLE;
        endcase
    end

    // inst_ready is forced low while reset is asserted, not just once state settles
    always_comb begin
        inst_ready = (state_q == IDLE) && rstn;
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xf_q        <= '0;
            remaining_q <= '0;
            hdr_addr_q  <= '0;
            tri_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_fire) begin
                        xf_q       <= inst.transform;
                        hdr_addr_q <= inst.model_id;
                    end
                end
                HDR_WAIT: begin
                    if (!hdr_empty) begin
                        tri_addr_q  <= hdr.base_addr;
                        remaining_q <= hdr.tri_count;
                    end
                end
                TRI_WAIT: begin
                    out_data_q  <= '{tri_v: tri_data, transform: xf_q};
                    out_valid_q <= 1'b1;
                    out_last_q  <= (remaining_q == COUNT_W'(1));
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        remaining_q <= remaining_q - COUNT_W'(1);
                        if (!out_last_q) tri_addr_q <= tri_addr_q + TRI_ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hdr_addr  = hdr_addr_q;
    assign tri_addr  = tri_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef SCHED_STATS_EN
    logic [31:0] stat_inst_q, stat_tri_q;
    logic [15:0] stat_drop_q;

    // All counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_inst_q <= '0;
            stat_tri_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            if (inst_fire && (stat_inst_q != '1)) stat_inst_q <= stat_inst_q + 32'd1;
            if (out_fire && (stat_tri_q != '1))   stat_tri_q  <= stat_tri_q + 32'd1;
            if ((state_q == HDR_WAIT) && hdr_empty && (stat_drop_q != '1))
                stat_drop_q <= stat_drop_q + 16'd1;
        end
    end

    assign stat_instances = stat_inst_q;
    assign stat_triangles = stat_tri_q;
    assign stat_dropped   = stat_drop_q;
`endif

endmodule

// File: tb/tb_model_instance_scheduler.sv
// Directed bench for model_instance_scheduler with behavioural header ROM and
// triangle RAM; statistics checks compile in when SCHED_STATS_EN is defined.
module tb_model_instance_scheduler;
    import types_pkg::*;

    logic                          clk = 1'b0;
    logic                          rstn;
    logic                          inst_valid;
    logic                          inst_ready;
    modelinstance_t                inst;
    logic [MODEL_ID_W-1:0]         hdr_addr;
    logic [TRI_ADDR_W+COUNT_W-1:0] hdr_data;
    logic [TRI_ADDR_W-1:0]         tri_addr;
    triangle_t                     tri_data;
    logic                          out_valid;
    logic                          out_ready;
    triangle_tf_t                  out_data;
    logic                          out_last;
    logic                          busy;
`ifdef SCHED_STATS_EN
    logic [31:0] stat_instances;
    logic [31:0] stat_triangles;
    logic [15:0] stat_dropped;
`endif

    int vectorCount = 0;
    int missCount   = 0;
    int hsCount     = 0;

    model_header_t hdrMem [256];

    model_instance_scheduler dut (
        .clk        (clk),
        .rstn       (rstn),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .hdr_addr   (hdr_addr),
        .hdr_data   (hdr_data),
        .tri_addr   (tri_addr),
        .tri_data   (tri_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
`ifdef SCHED_STATS_EN
        ,
        .stat_instances (stat_instances),
        .stat_triangles (stat_triangles),
        .stat_dropped   (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Triangle contents are a fixed function of the address so every output names its source
    function automatic triangle_t triOf(input logic [TRI_ADDR_W-1:0] a);
        triangle_t t;
        t.v0 = {4'h0, a};
        t.v1 = {4'hA, a};
        t.v2 = {4'h5, ~a};
        return t;
    endfunction

    always @(posedge clk) begin
        hdr_data <= hdrMem[hdr_addr];
        tri_data <= triOf(tri_addr);
        if (rstn && out_valid && out_ready) hsCount <= hsCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [MODEL_ID_W-1:0] id, input transform_t xf);
        int w;
        w = 0;
        @(negedge clk);
        inst       = '{model_id: id, transform: xf};
        inst_valid = 1'b1;
        while (!inst_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!inst_ready) begin
            checkOutput("instReadyTimeout", 128'(0), 128'(1));
            inst_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = modelinstance_t'(72'({$urandom(), $urandom(), $urandom()}));
    endtask

    // Consumes up to stopAfter triangles; stalls out_ready for 7 cycles on triangle stallAt
    task automatic checkStream(input int base, input int count, input transform_t xf,
                               input int stallAt, input int stopAfter, output int latency);
        int waitCyc;
        logic [TRI_ADDR_W-1:0] addr;
        triangle_tf_t exp;
        latency = 0;
        for (int k = 0; k < stopAfter; k++) begin
            waitCyc = 0;
            do begin
                @(negedge clk);
                waitCyc++;
            end while (!out_valid && waitCyc < 20);
            if (!out_valid) begin
                checkOutput("outValidTimeout", 128'(0), 128'(1));
                return;
            end
            if (k == 0) latency = waitCyc;
            addr = TRI_ADDR_W'(base + k);
            exp  = '{tri_v: triOf(addr), transform: xf};
            checkOutput("triAddr", 128'(tri_addr), 128'(addr));
            checkOutput("outData", 128'(out_data), 128'(exp));
            checkOutput("outLast", 128'(out_last), 128'(k == count - 1));
            if (k == stallAt) begin
                out_ready = 1'b0;
                repeat (7) begin
                    @(negedge clk);
                    checkOutput("stallValid", 128'(out_valid), 128'(1));
                    checkOutput("stallData", 128'(out_data), 128'(exp));
                    checkOutput("stallAddr", 128'(tri_addr), 128'(addr));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            checkOutput("validDropAfterHs", 128'(out_valid), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        transform_t xfA, xfB, xfC, xfD, xfE;
        int lat, hsBefore, w;

        for (int i = 0; i < 256; i++) hdrMem[i] = '0;
        hdrMem[1] = '{base_addr: 12'd10,   tri_count: 12'd3};
        hdrMem[2] = '{base_addr: 12'd50,   tri_count: 12'd0};
        hdrMem[3] = '{base_addr: 12'd30,   tri_count: 12'd1};
        hdrMem[4] = '{base_addr: 12'd100,  tri_count: 12'd3};
        hdrMem[5] = '{base_addr: 12'd4094, tri_count: 12'd3};
        hdrMem[6] = '{base_addr: 12'd200,  tri_count: 12'd4};
        hdrMem[7] = '{base_addr: 12'd20,   tri_count: 12'd2};

        xfA = '{tx: 16'h1111, ty: 16'h2222, tz: 16'h3333, scale: 16'h0100};
        xfB = '{tx: 16'hDEAD, ty: 16'hBEEF, tz: 16'h0042, scale: 16'h0200};
        xfC = '{tx: 16'h0F0F, ty: 16'hF0F0, tz: 16'h1234, scale: 16'h0080};
        xfD = '{tx: 16'h7777, ty: 16'h8888, tz: 16'h9999, scale: 16'h0400};
        xfE = '{tx: 16'hCAFE, ty: 16'hBABE, tz: 16'h5555, scale: 16'h0001};

        rstn       = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        out_ready  = 1'b1;
        #1;
        checkOutput("rstInstReady", 128'(inst_ready), 128'(0));
        checkOutput("rstOutValid", 128'(out_valid), 128'(0));
        checkOutput("rstOutLast", 128'(out_last), 128'(0));
        checkOutput("rstBusy", 128'(busy), 128'(0));
        checkOutput("rstHdrAddr", 128'(hdr_addr), 128'(0));
        checkOutput("rstTriAddr", 128'(tri_addr), 128'(0));
        checkOutput("rstOutData", 128'(out_data), 128'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("idleInstReady", 128'(inst_ready), 128'(1));

        $display("[TB] scenario 1: base 10, count 3");
        hsBefore = hsCount;
        applyStimulus(8'd1, xfA);
        checkStream(10, 3, xfA, -1, 3, lat);
        checkOutput("firstLatency", 128'(lat), 128'(5));
        checkOutput("s1Handshakes", 128'(hsCount - hsBefore), 128'(3));
        checkOutput("s1ReadyAfterLast", 128'(inst_ready), 128'(1));

        $display("[TB] scenario 2: dropped instance then count 1");
        hsBefore = hsCount;
        applyStimulus(8'd2, xfB);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!inst_ready && w < 10);
        checkOutput("dropReadyDelay", 128'(w), 128'(3));
        checkOutput("dropNoOutput", 128'(hsCount - hsBefore), 128'(0));
        applyStimulus(8'd3, xfC);
        checkStream(30, 1, xfC, -1, 1, lat);
        checkOutput("s2Handshakes", 128'(hsCount - hsBefore), 128'(1));

`ifdef SCHED_STATS_EN
        checkOutput("statInstances", 128'(stat_instances), 128'(3));
        checkOutput("statTriangles", 128'(stat_triangles), 128'(4));
        checkOutput("statDropped", 128'(stat_dropped), 128'(1));
`endif

        $display("[TB] scenario 3: backpressure on triangle 2");
        hsBefore = hsCount;
        applyStimulus(8'd4, xfD);
        checkStream(100, 3, xfD, 1, 3, lat);
        checkOutput("s3Handshakes", 128'(hsCount - hsBefore), 128'(3));

        $display("[TB] scenario 4: triangle address wrap");
        applyStimulus(8'd5, xfE);
        checkStream(4094, 3, xfE, -1, 3, lat);

        $display("[TB] scenario 5: reset mid-instance");
        applyStimulus(8'd6, xfA);
        checkStream(200, 4, xfA, -1, 1, lat);
        out_ready = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 20);
        checkOutput("midTriAddr", 128'(tri_addr), 128'(201));
        rstn = 1'b0;
        #1;
        checkOutput("midRstValid", 128'(out_valid), 128'(0));
        checkOutput("midRstBusy", 128'(busy), 128'(0));
        checkOutput("midRstReady", 128'(inst_ready), 128'(0));
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        hsBefore  = hsCount;
        applyStimulus(8'd7, xfB);
        checkStream(20, 2, xfB, -1, 2, lat);
        checkOutput("postRstLatency", 128'(lat), 128'(5));
        checkOutput("postRstHandshakes", 128'(hsCount - hsBefore), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
